vfb_sched: RTL and testbench

Frame-buffer scheduler for the video DMA path. It arbitrates burst requests between the video-in write channel and the video-out read channel onto the single DDR3 controller user command port. It also generates burst addresses and manages triple-buffer frame indices so that the read side only displays completed frames. It sits inside the DMA block, clocked by the DDR controller user clock, between the channel FIFOs and the memory controller.

---
 rtl/vfb_pkg.sv | 27 ++
 rtl/vfb_buf_mgr.sv | 101 ++++++++++
 rtl/vfb_sched.sv | 174 +++++++++++++++++
 tb/tb_vfb_sched.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfb_pkg.sv
// Shared types and helpers for the video frame-buffer scheduler.
package vfb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        CMD  = 2'd2
    } state_t;

    typedef logic [1:0] buf_idx_t;

    localparam logic CMD_WR = 1'b1;
    localparam logic CMD_RD = 1'b0;

    // Lowest buffer index in {0,1,2} that differs from both a and b.
    function automatic buf_idx_t pick_free(input buf_idx_t a, input buf_idx_t b);
        buf_idx_t r;
        r = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (buf_idx_t'(i) != a && buf_idx_t'(i) != b) begin
                r = buf_idx_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vfb_buf_mgr.sv
// Frame-start bookkeeping: pending vsync flags, triple-buffer indices,
// last completed write frame, and the short-frame counter.
// Triple buffering is built only when VFB_TRIPLE_BUF_EN is defined;
// otherwise both buffer indices are held at 0.
module vfb_buf_mgr
    import vfb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_frame_start,
    input  logic     rd_frame_start,
    input  logic     apply,        // scheduler is in ARB: pending starts take effect
    input  logic     wr_full,      // write counter has reached a full frame
    input  logic     wr_complete,  // handshake that finishes the write frame
    output logic     wr_restart,   // write start applied this cycle
    output logic     rd_restart,   // read start applied this cycle
    output buf_idx_t wr_buf,
    output buf_idx_t rd_buf,
    output buf_idx_t wr_buf_nxt,   // write index as seen after this cycle's starts
    output buf_idx_t rd_buf_nxt,   // read index as seen after this cycle's starts
    output logic [7:0] short_cnt
);

    logic       pend_wr_q, pend_wr_d;
    logic       pend_rd_q, pend_rd_d;
    logic [7:0] short_cnt_q, short_cnt_d;

    assign wr_restart = apply & pend_wr_q;
    assign rd_restart = apply & pend_rd_q;

    // Latch vsync pulses until ARB consumes them; count early write restarts.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        pend_wr_d   = (pend_wr_q & ~apply) | wr_frame_start;
        pend_rd_d   = (pend_rd_q & ~apply) | rd_frame_start;
        short_cnt_d = short_cnt_q;
        if (wr_restart && !wr_full && short_cnt_q != 8'hFF) begin
            short_cnt_d = short_cnt_q + 8'd1;
        end
    end

    // Pending flags and short-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            pend_wr_q   <= 1'b0;
            pend_rd_q   <= 1'b0;
            short_cnt_q <= 8'd0;
        end else begin
            pend_wr_q   <= pend_wr_d;
            pend_rd_q   <= pend_rd_d;
            short_cnt_q <= short_cnt_d;
        end
    end

    assign short_cnt = short_cnt_q;

`ifdef VFB_TRIPLE_BUF_EN
    buf_idx_t wr_buf_q, wr_buf_d;
    buf_idx_t rd_buf_q, rd_buf_d;
    buf_idx_t last_done_q, last_done_d;
    logic     done_valid_q, done_valid_d;

    // Read side jumps to the newest finished frame; write side takes the free one.
    always_comb begin
        rd_buf_d     = (rd_restart && done_valid_q) ? last_done_q : rd_buf_q;
        wr_buf_d     = wr_restart ? pick_free(rd_buf_d, last_done_q) : wr_buf_q;
        last_done_d  = wr_complete ? wr_buf_q : last_done_q;
        done_valid_d = done_valid_q | wr_complete;
    end

    // Buffer index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_buf_q     <= 2'd0;
            rd_buf_q     <= 2'd1;
            last_done_q  <= 2'd2;
            done_valid_q <= 1'b0;
        end else begin
            wr_buf_q     <= wr_buf_d;
            rd_buf_q     <= rd_buf_d;
            last_done_q  <= last_done_d;
            done_valid_q <= done_valid_d;
        end
    end

    assign wr_buf     = wr_buf_q;
    assign rd_buf     = rd_buf_q;
    assign wr_buf_nxt = wr_buf_d;
    assign rd_buf_nxt = rd_buf_d;
`else
    logic unused_complete;
    assign unused_complete = wr_complete;

    assign wr_buf     = 2'd0;
    assign rd_buf     = 2'd0;
    assign wr_buf_nxt = 2'd0;
    assign rd_buf_nxt = 2'd0;
`endif

endmodule

// File: rtl/vfb_sched.sv
// Frame-buffer scheduler: arbitrates write/read bursts onto the DDR user
// command port and generates burst addresses. Buffer index management is
// in vfb_buf_mgr; triple buffering is enabled by VFB_TRIPLE_BUF_EN.
module vfb_sched
    import vfb_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 28,
    parameter int unsigned       FRAME_BURSTS = 57600,
    parameter int unsigned       BURST_INC    = 8,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h0200000,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 28'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr_frame_start,
    input  logic              wr_req,
    output logic              wr_grant,
    input  logic              rd_frame_start,
    input  logic              rd_req,
    input  logic              rd_urgent,
    output logic              rd_grant,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output buf_idx_t          wr_buf,
    output buf_idx_t          rd_buf,
    output logic [7:0]        short_cnt
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_BURSTS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BURSTS);

    state_t            state_q, state_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              wr_grant_q, wr_grant_d;
    logic              rd_grant_q, rd_grant_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              last_rd_q, last_rd_d;

    logic              arb_active;
    logic              wr_full;
    logic              wr_complete;
    logic              wr_restart;
    logic              rd_restart;
    buf_idx_t          wr_buf_nxt;
    buf_idx_t          rd_buf_nxt;
    logic [CNT_W-1:0]  wr_cnt_eff;
    logic [CNT_W-1:0]  rd_cnt_eff;
    logic              wr_elig;
    logic              rd_elig;
    logic              pick_rd;
    logic              pick_wr;

    function automatic logic [ADDR_W-1:0] burst_addr(input buf_idx_t b, input logic [CNT_W-1:0] c);
        return BASE_ADDR + ADDR_W'(b) * FRAME_STRIDE + ADDR_W'(c) * ADDR_W'(BURST_INC);
    endfunction

    assign arb_active  = (state_q == ARB);
    assign wr_full     = (wr_cnt_q == CNT_FULL);
    assign wr_complete = (state_q == CMD) && cmd_ready && (cmd_we_q == CMD_WR)
                         && ((wr_cnt_q + 1'b1) == CNT_FULL);

    vfb_buf_mgr u_buf_mgr (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .apply          (arb_active),
        .wr_full        (wr_full),
        .wr_complete    (wr_complete),
        .wr_restart     (wr_restart),
        .rd_restart     (rd_restart),
        .wr_buf         (wr_buf),
        .rd_buf         (rd_buf),
        .wr_buf_nxt     (wr_buf_nxt),
        .rd_buf_nxt     (rd_buf_nxt),
        .short_cnt      (short_cnt)
    );

    // Counters as seen once this cycle's frame starts are applied.
    assign wr_cnt_eff = wr_restart ? '0 : wr_cnt_q;
    assign rd_cnt_eff = rd_restart ? '0 : rd_cnt_q;
    assign wr_elig    = wr_req && (wr_cnt_eff < CNT_FULL);
    assign rd_elig    = rd_req && (rd_cnt_eff < CNT_FULL);
    // Urgent read wins; otherwise round-robin when both are eligible.
    assign pick_rd    = rd_elig && (rd_urgent || !wr_elig || !last_rd_q);
    assign pick_wr    = wr_elig && !pick_rd;

    // Next-state, command capture and handshake bookkeeping.
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        wr_grant_d  = 1'b0;
        rd_grant_d  = 1'b0;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        last_rd_d   = last_rd_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                wr_cnt_d = wr_cnt_eff;
                rd_cnt_d = rd_cnt_eff;
                if (!enable) begin
                    state_d = IDLE;
                end else if (pick_rd || pick_wr) begin
                    state_d     = CMD;
                    cmd_valid_d = 1'b1;
                    cmd_we_d    = pick_rd ? CMD_RD : CMD_WR;
                    cmd_addr_d  = pick_rd ? burst_addr(rd_buf_nxt, rd_cnt_eff)
                                          : burst_addr(wr_buf_nxt, wr_cnt_eff);
                end
            end
            CMD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ARB;
                    last_rd_d   = (cmd_we_q == CMD_RD);
                    if (cmd_we_q == CMD_WR) begin
                        wr_grant_d = 1'b1;
                        wr_cnt_d   = wr_cnt_q + 1'b1;
                    end else begin
                        rd_grant_d = 1'b1;
                        rd_cnt_d   = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scheduler state and registered command/grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            wr_grant_q  <= 1'b0;
            rd_grant_q  <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            last_rd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            wr_grant_q  <= wr_grant_d;
            rd_grant_q  <= rd_grant_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            last_rd_q   <= last_rd_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_we    = cmd_we_q;
    assign cmd_addr  = cmd_addr_q;
    assign wr_grant  = wr_grant_q;
    assign rd_grant  = rd_grant_q;

endmodule

// File: tb/tb_vfb_sched.sv
// Scoreboard bench for vfb_sched with a 4-burst frame and 0x100 stride.
module tb_vfb_sched;

    localparam int FB   = 4;
    localparam int BINC = 8;

    typedef struct packed {
        logic        we;
        logic [27:0] addr;
    } cmd_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wr_frame_start;
    logic        wr_req;
    logic        wr_grant;
    logic        rd_frame_start;
    logic        rd_req;
    logic        rd_urgent;
    logic        rd_grant;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [27:0] cmd_addr;
    logic [1:0]  wr_buf;
    logic [1:0]  rd_buf;
    logic [7:0]  short_cnt;

    int   checks   = 0;
    int   failures = 0;
    cmd_t exp_q[$];
    cmd_t mon_e;
    logic hs_prev    = 1'b0;
    logic hs_prev_we = 1'b0;

    vfb_sched #(
        .ADDR_W       (28),
        .FRAME_BURSTS (FB),
        .BURST_INC    (BINC),
        .FRAME_STRIDE (28'h100),
        .BASE_ADDR    (28'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .wr_frame_start (wr_frame_start),
        .wr_req         (wr_req),
        .wr_grant       (wr_grant),
        .rd_frame_start (rd_frame_start),
        .rd_req         (rd_req),
        .rd_urgent      (rd_urgent),
        .rd_grant       (rd_grant),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_we         (cmd_we),
        .cmd_addr       (cmd_addr),
        .wr_buf         (wr_buf),
        .rd_buf         (rd_buf),
        .short_cnt      (short_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Buffer index the design should use: real index with triple buffering, else 0.
    function automatic int bval(input int b);
`ifdef VFB_TRIPLE_BUF_EN
        return b;
`else
        return 0 * b;
`endif
    endfunction

    function automatic logic [27:0] exp_addr(input int b, input int c);
        return 28'(bval(b) * 256 + c * BINC);
    endfunction

    task automatic push_cmd(input logic we, input int b, input int c);
        cmd_t e;
        e.we   = we;
        e.addr = exp_addr(b, c);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        enable         = 1'b0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        wr_req         = 1'b0;
        rd_req         = 1'b0;
        rd_urgent      = 1'b0;
        cmd_ready      = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_cmd_we"},    cmd_we,    0);
        check({tag, "_cmd_addr"},  cmd_addr,  0);
        check({tag, "_wr_grant"},  wr_grant,  0);
        check({tag, "_rd_grant"},  rd_grant,  0);
        check({tag, "_wr_buf"},    wr_buf,    bval(0));
        check({tag, "_rd_buf"},    rd_buf,    bval(1));
        check({tag, "_short_cnt"}, short_cnt, 0);
    endtask

    task automatic wait_valid(input int budget, input string name);
        for (int i = 0; i < budget && !cmd_valid; i++) step();
        check(name, cmd_valid, 1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        check(name, exp_q.size(), 0);
        repeat (2) step();
    endtask

    // Wait for n accepted commands; on the n-th, drop wr_req and optionally
    // pulse rd_frame_start so it coincides with that handshake edge.
    task automatic wait_hs(input int n, input bit coinc, input string name);
        int seen = 0;
        for (int i = 0; i < 100 && seen < n; i++) begin
            step();
            if (cmd_valid && cmd_ready) begin
                seen++;
                if (seen == n) begin
                    wr_req = 1'b0;
                    if (coinc) rd_frame_start = 1'b1;
                end
            end
        end
        check(name, seen, n);
        step();
        rd_frame_start = 1'b0;
    endtask

    task automatic pulse(input bit wr, input bit rd);
        wr_frame_start = wr;
        rd_frame_start = rd;
        step();
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        repeat (3) step();
    endtask

    // Monitor: checks grants against the previous handshake and pops the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_prev    = 1'b0;
            hs_prev_we = 1'b0;
        end else begin
            if (hs_prev || wr_grant || rd_grant) begin
                check("wr_grant", wr_grant, hs_prev && hs_prev_we);
                check("rd_grant", rd_grant, hs_prev && !hs_prev_we);
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_cmd", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cmd_we",   cmd_we,   mon_e.we);
                    check("cmd_addr", cmd_addr, mon_e.addr);
                end
            end
            hs_prev    = cmd_valid && cmd_ready;
            hs_prev_we = cmd_we;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Frame rotation table: mode 0 none, 1 read start on completion edge,
    // 2 read start after completion, 3 read and write start together.
    int mode_t  [4] = '{1, 0, 2, 3};
    int exp_rd_t[4] = '{1, 1, 2, 0};
    int exp_wr_t[4] = '{0, 2, 0, 1};

    initial begin
        int cur_wr;
        apply_reset();
        check_reset_outputs("rst0");

        // Write-only frame into buffer 0, then nothing more.
        for (int c = 0; c < FB; c++) push_cmd(1'b1, 0, c);
        enable = 1'b1;
        wr_req = 1'b1;
        wait_drain(100, "t1_drain");
        repeat (20) step();
        wr_req = 1'b0;

        // Round-robin: write first, then reads and writes alternate.
        apply_reset();
        for (int c = 0; c < FB; c++) begin
            push_cmd(1'b1, 0, c);
            push_cmd(1'b0, 1, c);
        end
        enable = 1'b1;
        wr_req = 1'b1;
        wait_valid(20, "t2_first_valid");
        rd_req = 1'b1;
        wait_drain(100, "t2_drain");
        wr_req = 1'b0;
        rd_req = 1'b0;

        // Urgent reads take the port first.
        apply_reset();
        for (int c = 0; c < FB; c++) push_cmd(1'b0, 1, c);
        for (int c = 0; c < FB; c++) push_cmd(1'b1, 0, c);
        enable    = 1'b1;
        wr_req    = 1'b1;
        rd_req    = 1'b1;
        rd_urgent = 1'b1;
        wait_drain(100, "t3_drain");
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        rd_urgent = 1'b0;

        // Frame 0 complete: read takes it, write moves to buffer 1.
        pulse(1'b0, 1'b1);
        check("t4_rd_buf", rd_buf, bval(0));
        pulse(1'b1, 1'b0);
        check("t4_wr_buf", wr_buf, bval(1));
        check("t4_short",  short_cnt, 0);

        cur_wr = 1;
        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < FB; c++) push_cmd(1'b1, cur_wr, c);
            wr_req = 1'b1;
            wait_hs(FB, mode_t[it] == 1, "rot_hs");
            wait_drain(50, "rot_drain");
            if (mode_t[it] == 2) pulse(1'b0, 1'b1);
            if (mode_t[it] == 3) pulse(1'b1, 1'b1);
            else                 pulse(1'b1, 1'b0);
            check("rot_rd_buf", rd_buf, bval(exp_rd_t[it]));
            check("rot_wr_buf", wr_buf, bval(exp_wr_t[it]));
`ifdef VFB_TRIPLE_BUF_EN
            check("rot_distinct", wr_buf != rd_buf, 1);
`endif
            cur_wr = exp_wr_t[it];
        end

        // Short frame: restart after 2 of 4 bursts.
        push_cmd(1'b1, cur_wr, 0);
        push_cmd(1'b1, cur_wr, 1);
        wr_req = 1'b1;
        wait_hs(2, 1'b0, "t5_hs");
        wait_drain(50, "t5_drain");
        pulse(1'b1, 1'b0);
        check("t5_short",  short_cnt, 1);
        check("t5_wr_buf", wr_buf, bval(1));
        check("t5_rd_buf", rd_buf, bval(0));

        // Back-pressure: command held stable for 10 cycles.
        cmd_ready = 1'b0;
        push_cmd(1'b1, 1, 0);
        wr_req = 1'b1;
        wait_valid(20, "bp_first_valid");
        wr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", cmd_valid, 1);
            check("bp_we",    cmd_we,    1);
            check("bp_addr",  cmd_addr,  exp_addr(1, 0));
            check("bp_grant", wr_grant,  0);
            step();
        end
        cmd_ready = 1'b1;
        wait_drain(20, "bp_drain");

        // Reset asserted while a command is outstanding.
        cmd_ready = 1'b0;
        wr_req    = 1'b1;
        wait_valid(20, "t6_valid");
        wr_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", cmd_valid, 0);
        repeat (2) step();
        cmd_ready = 1'b1;
        rst_n     = 1'b1;
        step();
        check_reset_outputs("rst1");
        repeat (5) step();
        check("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
